// File: rtl/uart_rx_frame_detector_pkg.sv
// Shared types, oversampling constants and bit-vote helper for the UART RX frame detector.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int OSR_16 = 16;
  localparam int OSR_8  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_detector_if.sv
// Frame output channel: data plus error flags under a valid/ready handshake.
interface uart_rx_frame_detector_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic                 framing_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (output data_out, data_out_valid, framing_err, parity_err, overrun_err,
                  input  data_out_ready);
  modport slave  (input  data_out, data_out_valid, framing_err, parity_err, overrun_err,
                  output data_out_ready);
endinterface

// File: rtl/uart_rx_frame_detector_counter.sv
// Generic loadable up-counter used for the sample, low-sample and bit-index counts.
module uart_rx_frame_detector_counter #(
  parameter int WIDTH     = 4,
  parameter int STEP      = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= WIDTH'(RESET_VAL);
    else if (i_load) r_cnt <= i_load_val;
    else if (i_inc)  r_cnt <= r_cnt + WIDTH'(STEP);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/uart_rx_frame_detector.sv
// Oversampled UART RX frame assembler with start validation and 3-sample bit voting.
// Optional parity bit/check enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame_detector
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int START_LOW_THRES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sample_en,
  input  logic i_bitstream_in,
  input  logic i_oversample_x16,
`ifdef UART_RX_PARITY_EN
  input  logic i_parity_odd,
`endif
  uart_rx_frame_detector_if.master o_rx
);
  localparam int              BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [4:0]      THR16    = 5'(START_LOW_THRES);
  localparam logic [4:0]      THR8     = 5'(START_LOW_THRES / 2);

  rx_state_t            r_state;
  logic                 r_osr16, r_v0, r_v1;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_ferr, r_ovr;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr, r_perr_q;
`endif

  logic [3:0]    w_samp;
  logic [4:0]    w_low, w_low_tot, w_n, w_half, w_idx, w_thr;
  logic [BW-1:0] w_bit;
  logic          w_last, w_at_v0, w_at_v1, w_at_vote, w_vote, w_drain;
  logic          w_samp_ld, w_samp_inc, w_low_ld, w_low_inc, w_bit_ld, w_bit_inc;
  logic [3:0]    w_samp_ldv;

  // w_idx is the 1-based position within the current bit of the sample arriving now
  assign w_n       = r_osr16 ? 5'(OSR_16) : 5'(OSR_8);
  assign w_half    = w_n >> 1;
  assign w_thr     = r_osr16 ? THR16 : THR8;
  assign w_idx     = {1'b0, w_samp} + 5'd1;
  assign w_last    = (w_idx == w_n);
  assign w_at_v0   = (w_idx == w_half - 5'd1);
  assign w_at_v1   = (w_idx == w_half);
  assign w_at_vote = (w_idx == w_half + 5'd1);
  assign w_vote    = maj3(r_v0, r_v1, i_bitstream_in);
  assign w_low_tot = w_low + {4'b0, ~i_bitstream_in};
  assign w_drain   = r_valid & o_rx.data_out_ready;

  always_comb begin
    w_samp_ld  = 1'b0;
    w_samp_ldv = 4'd0;
    w_samp_inc = 1'b0;
    if (i_sample_en) begin
      case (r_state)
        IDLE: begin w_samp_ld = 1'b1; w_samp_ldv = {3'b0, ~i_bitstream_in}; end
        STOP: if (w_at_vote) w_samp_ld = 1'b1; else w_samp_inc = 1'b1;
        default: if (w_last) w_samp_ld = 1'b1; else w_samp_inc = 1'b1;
      endcase
    end
  end

  assign w_low_ld  = i_sample_en & (r_state == IDLE);
  assign w_low_inc = i_sample_en & (r_state == START) & ~i_bitstream_in;
  assign w_bit_ld  = i_sample_en & (r_state != DATA);
  assign w_bit_inc = i_sample_en & (r_state == DATA) & w_last;

  uart_rx_frame_detector_counter #(.WIDTH(4), .STEP(1), .RESET_VAL(0)) u_samp_cnt (
    .clk(clk), .rst_n(rst_n), .i_load(w_samp_ld), .i_load_val(w_samp_ldv),
    .i_inc(w_samp_inc), .o_cnt(w_samp));

  uart_rx_frame_detector_counter #(.WIDTH(5), .STEP(1), .RESET_VAL(0)) u_low_cnt (
    .clk(clk), .rst_n(rst_n), .i_load(w_low_ld), .i_load_val({4'b0, ~i_bitstream_in}),
    .i_inc(w_low_inc), .o_cnt(w_low));

  uart_rx_frame_detector_counter #(.WIDTH(BW), .STEP(1), .RESET_VAL(0)) u_bit_idx (
    .clk(clk), .rst_n(rst_n), .i_load(w_bit_ld), .i_load_val('0),
    .i_inc(w_bit_inc), .o_cnt(w_bit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_osr16 <= 1'b0;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr   <= 1'b0;
      r_perr_q <= 1'b0;
`endif
    end else begin
      r_ovr <= 1'b0;
      if (w_drain) r_valid <= 1'b0;
      if (i_sample_en) begin
        if (w_at_v0) r_v0 <= i_bitstream_in;
        if (w_at_v1) r_v1 <= i_bitstream_in;
        case (r_state)
          IDLE: if (!i_bitstream_in) begin
            r_state <= START;
            r_osr16 <= i_oversample_x16;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
          end
          START: if (w_last) r_state <= (w_low_tot >= w_thr) ? DATA : IDLE;
          DATA: begin
            if (w_at_vote) r_shift[w_bit] <= w_vote;
`ifdef UART_RX_PARITY_EN
            if (w_last && w_bit == LAST_BIT) r_state <= PARITY;
`else
            if (w_last && w_bit == LAST_BIT) r_state <= STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_at_vote) r_perr <= ((w_vote ^ (^r_shift)) != i_parity_odd);
            if (w_last) r_state <= STOP;
          end
`endif
          // Leave at mid-stop so a back-to-back frame's falling edge is not missed
          STOP: if (w_at_vote) begin
            r_state <= IDLE;
            if (!r_valid || o_rx.data_out_ready) begin
              r_data  <= r_shift;
              r_ferr  <= ~w_vote;
              r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_perr_q <= r_perr;
`endif
            end else begin
              r_ovr <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_rx.data_out       = r_data;
  assign o_rx.data_out_valid = r_valid;
  assign o_rx.framing_err    = r_ferr;
  assign o_rx.overrun_err    = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign o_rx.parity_err     = r_perr_q;
`else
  assign o_rx.parity_err     = 1'b0;
`endif
endmodule
